// File: rtl/agc_wl_injector.sv
// agc_wl_injector: drives the AGC write lines (WL_n) and the NISQ/EXT/STRT1
// strobes to inject one instruction word at a time, optionally preceded by
// an EXTEND prefix pulse.
//
// Ports:
//   CLOCK      - single clock, rising edge
//   SIM_RST_n  - asynchronous active-low reset
//   CMD_VALID  - instruction word offered
//   CMD_WORD   - 16-bit instruction word (bit0 = WL01)
//   CMD_EXT    - precede the word with an EXTEND prefix
//   CMD_READY  - injector can accept a command
//   START_REQ  - request a STRT1 pulse (wins over CMD_VALID)
//   WL_n       - active-low write lines
//   NISQ, EXT, STRT1 - active-high strobes
//   BUSY       - high whenever not idle
//   INJ_COUNT  - completed-injection counter (only with INJ_COUNT_EN defined)
//
// Optional feature macro: INJ_COUNT_EN adds the INJ_COUNT output.
module agc_wl_injector #(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 5,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned STRT_CYC  = 20
) (
    input  logic        CLOCK,
    input  logic        SIM_RST_n,
    input  logic        CMD_VALID,
    input  logic [15:0] CMD_WORD,
    input  logic        CMD_EXT,
    output logic        CMD_READY,
    input  logic        START_REQ,
    output logic [15:0] WL_n,
    output logic        NISQ,
    output logic        EXT,
    output logic        STRT1,
    output logic        BUSY
`ifdef INJ_COUNT_EN
    ,
    output logic [15:0] INJ_COUNT
`endif
);

    // Zero-valued parameters behave as one cycle; counter loads are N-1.
    localparam int unsigned SETUP_E = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
    localparam int unsigned PULSE_E = (PULSE_CYC == 0) ? 1 : PULSE_CYC;
    localparam int unsigned HOLD_E  = (HOLD_CYC  == 0) ? 1 : HOLD_CYC;
    localparam int unsigned STRT_E  = (STRT_CYC  == 0) ? 1 : STRT_CYC;
    localparam logic [7:0]  SETUP_LD = 8'(SETUP_E - 1);
    localparam logic [7:0]  PULSE_LD = 8'(PULSE_E - 1);
    localparam logic [7:0]  HOLD_LD  = 8'(HOLD_E - 1);
    localparam logic [7:0]  STRT_LD  = 8'(STRT_E - 1);

    typedef enum logic [2:0] {
        IDLE, STRT, EXTP, EXTG, SETUP, PULSE, HOLD
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_word, w_word_nxt;
    logic        r_ready;
    logic [15:0] r_wl_n;
    logic        r_nisq, r_ext, r_strt1, r_busy;
    logic        w_cnt_zero;
    logic        w_word_phase;

    assign w_cnt_zero = (r_cnt == 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        unique case (r_state)
            IDLE: begin
                // r_ready is low on the first cycle out of reset, so nothing
                // is accepted before CMD_READY has been visible.
                if (r_ready) begin
                    if (START_REQ) begin
                        w_state_nxt = STRT;
                        w_cnt_nxt   = STRT_LD;
                    end else if (CMD_VALID) begin
                        w_word_nxt = CMD_WORD;
                        if (CMD_EXT) begin
                            w_state_nxt = EXTP;
                            w_cnt_nxt   = PULSE_LD;
                        end else begin
                            w_state_nxt = SETUP;
                            w_cnt_nxt   = SETUP_LD;
                        end
                    end
                end
            end
            STRT: begin
                if (w_cnt_zero) w_state_nxt = IDLE;
                else            w_cnt_nxt   = r_cnt - 8'd1;
            end
            EXTP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = EXTG;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            EXTG: begin
                if (w_cnt_zero) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = PULSE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            HOLD: begin
                if (w_cnt_zero) w_state_nxt = IDLE;
                else            w_cnt_nxt   = r_cnt - 8'd1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign w_word_phase = (w_state_nxt == SETUP) || (w_state_nxt == PULSE) ||
                          (w_state_nxt == HOLD);

    // Outputs are registered from the next state so each strobe comes
    // straight off a flop and cannot glitch.
    always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_word  <= 16'h0000;
            r_ready <= 1'b0;
            r_wl_n  <= 16'hFFFF;
            r_nisq  <= 1'b0;
            r_ext   <= 1'b0;
            r_strt1 <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_wl_n  <= w_word_phase ? ~w_word_nxt : 16'hFFFF;
            r_nisq  <= (w_state_nxt == EXTP) || (w_state_nxt == PULSE);
            r_ext   <= (w_state_nxt == EXTP);
            r_strt1 <= (w_state_nxt == STRT);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

`ifdef INJ_COUNT_EN
    logic [15:0] r_inj_count;

    always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            r_inj_count <= 16'h0000;
        end else if ((r_state == HOLD) && w_cnt_zero) begin
            r_inj_count <= r_inj_count + 16'd1;
        end
    end

    assign INJ_COUNT = r_inj_count;
`endif

    // START_REQ has priority in IDLE, so readiness is withdrawn while it is high.
    assign CMD_READY = r_ready & ~START_REQ;
    assign WL_n      = r_wl_n;
    assign NISQ      = r_nisq;
    assign EXT       = r_ext;
    assign STRT1     = r_strt1;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_agc_wl_injector.sv
// tb_agc_wl_injector: directed + randomized bench for agc_wl_injector.
// Expected outputs come from a per-cycle phase model (arithmetic on the
// cycle offset after acceptance). INJ_COUNT is checked when INJ_COUNT_EN is defined.
module tb_agc_wl_injector;

    localparam int S = 4;
    localparam int P = 5;
    localparam int H = 4;
    localparam int T = 20;

    logic        CLOCK;
    logic        SIM_RST_n;
    logic        CMD_VALID;
    logic [15:0] CMD_WORD;
    logic        CMD_EXT;
    logic        CMD_READY;
    logic        START_REQ;
    logic [15:0] WL_n;
    logic        NISQ;
    logic        EXT;
    logic        STRT1;
    logic        BUSY;
`ifdef INJ_COUNT_EN
    logic [15:0] INJ_COUNT;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int model_count = 0;

    agc_wl_injector #(
        .SETUP_CYC(S),
        .PULSE_CYC(P),
        .HOLD_CYC (H),
        .STRT_CYC (T)
    ) dut (
        .CLOCK    (CLOCK),
        .SIM_RST_n(SIM_RST_n),
        .CMD_VALID(CMD_VALID),
        .CMD_WORD (CMD_WORD),
        .CMD_EXT  (CMD_EXT),
        .CMD_READY(CMD_READY),
        .START_REQ(START_REQ),
        .WL_n     (WL_n),
        .NISQ     (NISQ),
        .EXT      (EXT),
        .STRT1    (STRT1),
        .BUSY     (BUSY)
`ifdef INJ_COUNT_EN
        ,
        .INJ_COUNT(INJ_COUNT)
`endif
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [15:0] wl;
        logic        nisq;
        logic        ext;
        logic        busy;
    } exp_t;

    // Expected outputs in cycle c (1-based) after the accepting edge.
    function automatic exp_t exp_out(input int c, input logic x, input logic [15:0] w);
        exp_t e;
        int   d;
        e.busy = 1'b1;
        d = c;
        if (x) begin
            if (c <= P) begin
                e.wl = 16'hFFFF; e.nisq = 1'b1; e.ext = 1'b1;
                return e;
            end
            if (c <= P + H) begin
                e.wl = 16'hFFFF; e.nisq = 1'b0; e.ext = 1'b0;
                return e;
            end
            d = c - (P + H);
        end
        e.wl   = ~w;
        e.ext  = 1'b0;
        e.nisq = (d > S) && (d <= S + P);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_ready);
        chk({tag, ".wl"},    32'(WL_n),  32'hFFFF);
        chk({tag, ".nisq"},  32'(NISQ),  32'd0);
        chk({tag, ".ext"},   32'(EXT),   32'd0);
        chk({tag, ".strt1"}, 32'(STRT1), 32'd0);
        chk({tag, ".busy"},  32'(BUSY),  32'd0);
        chk({tag, ".ready"}, 32'(CMD_READY), 32'(exp_ready));
    endtask

    // Called at a negedge with the DUT idle; offers one command and follows
    // it cycle by cycle. abort_at > 0 returns early at that cycle's negedge.
    task automatic run_cmd(input logic [15:0] w, input logic x, input int abort_at);
        int   total;
        exp_t e;
        total = (x ? P + H : 0) + S + P + H;
        CMD_VALID = 1'b1;
        CMD_WORD  = w;
        CMD_EXT   = x;
        START_REQ = 1'b0;
        #1 chk("ready_at_offer", 32'(CMD_READY), 32'd1);
        for (int c = 1; c <= total; c++) begin
            @(negedge CLOCK);
            e = exp_out(c, x, w);
            chk("wl",    32'(WL_n),  32'(e.wl));
            chk("nisq",  32'(NISQ),  32'(e.nisq));
            chk("ext",   32'(EXT),   32'(e.ext));
            chk("strt1", 32'(STRT1), 32'd0);
            chk("busy",  32'(BUSY),  32'(e.busy));
            chk("ready_busy", 32'(CMD_READY), 32'd0);
            if (abort_at == c) return;
            // Noise on inputs that must be ignored while busy.
            CMD_WORD  = 16'($urandom);
            CMD_EXT   = 1'($urandom_range(0, 1));
            CMD_VALID = (c < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            START_REQ = (c < total) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge CLOCK);
        chk_idle("after_cmd", 1'b1);
        model_count = (model_count + 1) & 32'hFFFF;
`ifdef INJ_COUNT_EN
        chk("inj_count", 32'(INJ_COUNT), 32'(model_count));
`endif
    endtask

    initial begin
        logic [15:0] w;
        logic        x;
        int          gap;

        // Reset held: idle values regardless of inputs.
        SIM_RST_n = 1'b0;
        CMD_VALID = 1'b1;
        CMD_WORD  = 16'hA5A5;
        CMD_EXT   = 1'b0;
        START_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            chk_idle("in_reset", 1'b0);
        end
        CMD_VALID = 1'b0;
        SIM_RST_n = 1'b1;
        #1 chk("ready_before_edge", 32'(CMD_READY), 32'd0);
        @(negedge CLOCK);
        chk_idle("after_release", 1'b1);
`ifdef INJ_COUNT_EN
        chk("inj_count_reset", 32'(INJ_COUNT), 32'd0);
`endif

        // Plain command, then the same word behind an EXTEND prefix.
        run_cmd(16'o30000, 1'b0, 0);
        run_cmd(16'h1234, 1'b1, 0);

        // START_REQ wins over a simultaneous CMD_VALID.
        START_REQ = 1'b1;
        CMD_VALID = 1'b1;
        CMD_WORD  = 16'h0F0F;
        CMD_EXT   = 1'b0;
        #1 chk("ready_with_start", 32'(CMD_READY), 32'd0);
        for (int c = 1; c <= T; c++) begin
            @(negedge CLOCK);
            START_REQ = 1'b0;
            chk("strt.strt1", 32'(STRT1), 32'd1);
            chk("strt.busy",  32'(BUSY),  32'd1);
            chk("strt.wl",    32'(WL_n),  32'hFFFF);
            chk("strt.nisq",  32'(NISQ),  32'd0);
            chk("strt.ext",   32'(EXT),   32'd0);
            chk("strt.ready", 32'(CMD_READY), 32'd0);
        end
        @(negedge CLOCK);
        chk_idle("after_strt", 1'b1);
        run_cmd(16'h0F0F, 1'b0, 0);

        // Randomized commands with idle gaps.
        for (int k = 0; k < 24; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                CMD_VALID = 1'b0;
                START_REQ = 1'b0;
                @(negedge CLOCK);
                chk_idle("gap", 1'b1);
            end
            w = 16'($urandom);
            x = 1'($urandom_range(0, 1));
            run_cmd(w, x, 0);
        end

        // Reset during PULSE: idle values without a clock edge, nothing late.
        run_cmd(16'h7777, 1'b0, S + 2);
        CMD_VALID = 1'b0;
        START_REQ = 1'b0;
        #2 SIM_RST_n = 1'b0;
        #1 chk_idle("async_reset", 1'b0);
        model_count = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLOCK);
            chk_idle("reset_hold", 1'b0);
        end
        SIM_RST_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLOCK);
            chk_idle("post_abort", 1'b1);
        end
`ifdef INJ_COUNT_EN
        chk("inj_count_after_reset", 32'(INJ_COUNT), 32'd0);
`endif
        run_cmd(16'hBEEF, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
